// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the multicycle divider and,
// later, by the multiplier unit.
//   DATA_W      : default operand/result width
//   CNT_W       : width of an iteration counter covering DATA_W steps
//   div_state_t : divider control states
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider handshake bundle.
//   div_start          : start request (control unit -> divider)
//   dividend, divisor  : signed operands rs / rt (control unit -> divider)
//   div_hi, div_lo     : remainder / quotient (divider -> HI/LO muxes)
//   div_busy, div_done : status, done is a one-cycle pulse
//   div_zero           : divide-by-zero flag, valid with div_done
interface div_unit_if #(
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic                     div_start;
  logic signed [DATA_W-1:0] dividend;
  logic signed [DATA_W-1:0] divisor;
  logic        [DATA_W-1:0] div_hi;
  logic        [DATA_W-1:0] div_lo;
  logic                     div_busy;
  logic                     div_done;
  logic                     div_zero;

  modport master (
    output div_start, dividend, divisor,
    input  div_hi, div_lo, div_busy, div_done, div_zero
  );

  modport slave (
    input  div_start, dividend, divisor,
    output div_hi, div_lo, div_busy, div_done, div_zero
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem_i  : partial remainder before the step (always < divisor)
//   quo_i  : quotient/dividend shift register before the step
//   dvsr_i : divisor magnitude
//   rem_o  : partial remainder after the step
//   quo_o  : shift register after the step, new quotient bit in bit 0
module div_step #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic        [DATA_W:0] shifted;
  logic signed [DATA_W:0] trial;

  // rem < divisor <= 2^(DATA_W-1), so the shifted remainder fits in
  // DATA_W+1 bits and the trial's top bit is a reliable sign.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    trial   = shifted - {1'b0, dvsr_i};
    if (!trial[DATA_W]) begin
      rem_o = trial[DATA_W-1:0];
    end else begin
      rem_o = shifted[DATA_W-1:0];
    end
    quo_o = {quo_i[DATA_W-2:0], ~trial[DATA_W]};
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider for the MIPS div instruction.
// div_lo = quotient truncated toward zero, div_hi = remainder with the
// dividend's sign. Works on magnitudes with one restoring step per clock,
// then fixes signs in a single FIX cycle.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : div_unit_if slave (start/operands in, results/status out)
module div_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DATA_W);

  div_state_t        state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;

  // Magnitude in DATA_W unsigned bits; -2^(W-1) maps to 2^(W-1).
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x;
    if (x[DATA_W-1]) begin
      r = ~r + 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x,
                                               input logic             en);
    return en ? (~x + 1'b1) : x;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.div_start) begin
          if (bus.divisor == '0) begin
            // Results are left untouched; only the flag reports the error.
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = mag(bus.dividend);
            dvsr_d  = mag(bus.divisor);
            rem_d   = '0;
            sa_d    = bus.dividend[DATA_W-1];
            sb_d    = bus.divisor[DATA_W-1];
            cnt_d   = CW'(DATA_W - 1);
            zero_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = neg_if(quo_q, sa_q ^ sb_q);
        hi_d    = neg_if(rem_q, sa_q);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.div_hi   = hi_q;
  assign bus.div_lo   = lo_q;
  assign bus.div_busy = busy_q;
  assign bus.div_done = done_q;
  assign bus.div_zero = zero_q;

endmodule
